// File: rtl/cnnpr_mem_pkg.sv
// Shared constants, entry field offsets and reader FSM encoding for the block-column cache.
// Each 162-bit entry packs two 80-bit column lanes plus one help flag per lane.
package cnnpr_mem_pkg;
   localparam int DATA_WIDTH   = 8;
   localparam int BLOCK_WIDTH  = 10;
   localparam int BLOCK_HEIGTH = 10;
   localparam int NUM_BLOCK_H  = 4;
   localparam int LANE_WIDTH   = DATA_WIDTH * BLOCK_WIDTH;
   localparam int CACHE_WIDTH  = 2 * LANE_WIDTH + 2;

   localparam int HELP_HI = 161;
   localparam int HELP_LO = 160;
   localparam int HI_MSB  = 159;
   localparam int LO_MSB  = 79;

   localparam int ROW_W = $clog2(BLOCK_HEIGTH);
   localparam int IDX_W = $clog2(NUM_BLOCK_H);

   typedef logic [LANE_WIDTH-1:0] lane_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      LOAD    = 2'd2,
      PRESENT = 2'd3
   } rd_state_t;
endpackage

// File: rtl/cache_reader_if.sv
// Cache-pop side plus the two column-lane handshakes and block/fmap status of the reader.
// master = cache_reader, slave = cache/PE-array/scheduler side.
interface cache_reader_if;
   import cnnpr_mem_pkg::*;

   logic                   empty;
   logic                   read_req;
   logic [CACHE_WIDTH-1:0] data_in;
   lane_t                  lo_data;
   lane_t                  hi_data;
   logic                   lo_help;
   logic                   hi_help;
   logic                   lo_valid;
   logic                   hi_valid;
   logic                   lo_ready;
   logic                   hi_ready;
   logic                   lo_block_done;
   logic                   hi_block_done;
   logic [IDX_W-1:0]       lo_blk_idx;
   logic [IDX_W-1:0]       hi_blk_idx;
   logic                   fmap_done;

   modport master (
      input  empty, data_in, lo_ready, hi_ready,
      output read_req, lo_data, hi_data, lo_help, hi_help, lo_valid, hi_valid,
             lo_block_done, hi_block_done, lo_blk_idx, hi_blk_idx, fmap_done
   );

   modport slave (
      output empty, data_in, lo_ready, hi_ready,
      input  read_req, lo_data, hi_data, lo_help, hi_help, lo_valid, hi_valid,
             lo_block_done, hi_block_done, lo_blk_idx, hi_blk_idx, fmap_done
   );
endinterface

// File: rtl/cache_lane_out.sv
// One column lane: holds a loaded word until accepted (valid drops the cycle after valid&ready),
// counts own/helped rows and pulses block_done one cycle after an own block's last row is accepted.
module cache_lane_out
   import cnnpr_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             load,
   input  lane_t            din,
   input  logic             help_in,
   input  logic             ready,
   output lane_t            data,
   output logic             help,
   output logic             valid,
   output logic             block_done,
   output logic [IDX_W-1:0] blk_idx,
   output logic             fmap_wrap
);
   logic             accept;
   logic             row_last;
   logic             help_last;
   logic             idx_last;
   logic [ROW_W-1:0] row_cnt;
   logic [ROW_W-1:0] help_cnt;

   assign accept    = clk_en & valid & ready;
   assign row_last  = (row_cnt  == ROW_W'(BLOCK_HEIGTH - 1));
   assign help_last = (help_cnt == ROW_W'(BLOCK_HEIGTH - 1));
   assign idx_last  = (blk_idx  == IDX_W'(NUM_BLOCK_H - 1));
   assign fmap_wrap = accept & ~help & row_last & idx_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         help  <= 1'b0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= din;
         help  <= help_in;
         valid <= 1'b1;
      end else if (accept) begin
         valid <= 1'b0;
      end
   end

   // Helped rows belong to the partner block, so they never advance row_cnt or blk_idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt  <= '0;
         help_cnt <= '0;
         blk_idx  <= '0;
      end else if (accept) begin
         if (help) begin
            help_cnt <= help_last ? '0 : help_cnt + 1'b1;
         end else begin
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            if (row_last) begin
               blk_idx <= idx_last ? '0 : blk_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         block_done <= 1'b0;
      end else if (clk_en) begin
         block_done <= accept & ~help & row_last;
      end
   end
endmodule

// File: rtl/cache_reader.sv
// Pops one cache entry per FETCH/LOAD/PRESENT round (>= 3 cycles) and splits it into two lanes;
// the next pop waits until both lanes have accepted, and fmap_done pulses once both lanes wrap blk_idx.
module cache_reader
   import cnnpr_mem_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clk_en,
   cache_reader_if.master bus
);
   rd_state_t state;
   rd_state_t state_nxt;
   logic      load;
   logic      lo_clear;
   logic      hi_clear;
   logic      lo_wrap;
   logic      hi_wrap;
   logic      lo_stk;
   logic      hi_stk;

   assign lo_clear = ~bus.lo_valid | bus.lo_ready;
   assign hi_clear = ~bus.hi_valid | bus.hi_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (clk_en) begin
         state <= state_nxt;
      end
   end

   // FETCH only advances on an actual pop, so an empty cache never loses a slot.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.empty) state_nxt = FETCH;
         FETCH:   if (!bus.empty) state_nxt = LOAD;
         LOAD:    state_nxt = PRESENT;
         PRESENT: if (lo_clear && hi_clear) state_nxt = bus.empty ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.read_req = 1'b0;
      load         = 1'b0;
      if (clk_en) begin
         bus.read_req = (state == FETCH) && !bus.empty;
         load         = (state == LOAD);
      end
   end

   cache_lane_out u_lo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .load       (load),
      .din        (bus.data_in[LO_MSB:0]),
      .help_in    (bus.data_in[HELP_LO]),
      .ready      (bus.lo_ready),
      .data       (bus.lo_data),
      .help       (bus.lo_help),
      .valid      (bus.lo_valid),
      .block_done (bus.lo_block_done),
      .blk_idx    (bus.lo_blk_idx),
      .fmap_wrap  (lo_wrap)
   );

   cache_lane_out u_hi (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .load       (load),
      .din        (bus.data_in[HI_MSB:LO_MSB+1]),
      .help_in    (bus.data_in[HELP_HI]),
      .ready      (bus.hi_ready),
      .data       (bus.hi_data),
      .help       (bus.hi_help),
      .valid      (bus.hi_valid),
      .block_done (bus.hi_block_done),
      .blk_idx    (bus.hi_blk_idx),
      .fmap_wrap  (hi_wrap)
   );

   // fmap_done is visible while both sticky bits are set; the next enabled edge clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_stk <= 1'b0;
         hi_stk <= 1'b0;
      end else if (clk_en) begin
         lo_stk <= (lo_stk & ~bus.fmap_done) | lo_wrap;
         hi_stk <= (hi_stk & ~bus.fmap_done) | hi_wrap;
      end
   end

   assign bus.fmap_done = lo_stk & hi_stk;
endmodule

// File: tb/tb_cache_reader.sv
// Directed bench for cache_reader: table of single-entry transfers plus hand-written multi-cycle sequences.
module tb_cache_reader;
   import cnnpr_mem_pkg::*;

   typedef struct {
      logic [CACHE_WIDTH-1:0] entry;
      logic [79:0]            exp_lo;
      logic [79:0]            exp_hi;
      logic                   exp_lo_help;
      logic                   exp_hi_help;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   lo_pulses, hi_pulses, fm_pulses, lo_acc, hi_acc, lo_at, hi_at;
   logic [CACHE_WIDTH-1:0] q[$];
   vec_t vt[4];

   cache_reader_if bus ();

   cache_reader dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   // Cache model: a pop seen mid-cycle is served just after the next edge, like a registered FIFO.
   initial begin
      logic rr;
      bus.empty   = 1'b1;
      bus.data_in = '0;
      forever begin
         @(negedge clk);
         rr = bus.read_req;
         @(posedge clk);
         #1;
         if (rr && q.size() > 0) bus.data_in = q.pop_front();
         bus.empty = (q.size() == 0);
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_rr(string name);
      int n = 0;
      while (bus.read_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_read_req_rise"}, bus.read_req, 1'b1);
   endtask

   task automatic do_reset();
      bus.lo_ready = 1'b1;
      bus.hi_ready = 1'b1;
      clk_en = 1'b1;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push_normal(int n, int base);
      for (int i = 0; i < n; i++) q.push_back({2'b00, 80'(base + i), 80'(base + i + 7)});
   endtask

   task automatic monitor(int cycles);
      lo_pulses = 0; hi_pulses = 0; fm_pulses = 0;
      lo_acc = 0; hi_acc = 0; lo_at = -1; hi_at = -1;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (bus.lo_block_done) begin lo_pulses++; lo_at = lo_acc; end
         if (bus.hi_block_done) begin hi_pulses++; hi_at = hi_acc; end
         if (bus.fmap_done) fm_pulses++;
         if (bus.lo_valid && bus.lo_ready) lo_acc++;
         if (bus.hi_valid && bus.hi_ready) hi_acc++;
      end
   endtask

   initial begin
      vt[0] = '{{2'b00, 80'hAAAA_AAAA_AAAA_AAAA_AAAA, 80'h5555_5555_5555_5555_5555},
                80'h5555_5555_5555_5555_5555, 80'hAAAA_AAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0};
      vt[1] = '{{2'b01, 80'h0123_4567_89AB_CDEF_0011, 80'hFEDC_BA98_7654_3210_0FF0},
                80'hFEDC_BA98_7654_3210_0FF0, 80'h0123_4567_89AB_CDEF_0011, 1'b1, 1'b0};
      vt[2] = '{{2'b10, 80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF},
                80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0, 1'b0, 1'b1};
      vt[3] = '{{2'b11, 80'h8000_0000_0000_0000_0001, 80'h0102_0304_0506_0708_090A},
                80'h0102_0304_0506_0708_090A, 80'h8000_0000_0000_0000_0001, 1'b1, 1'b1};

      bus.lo_ready = 1'b1;
      bus.hi_ready = 1'b1;
      tick();
      chk("rst_read_req", bus.read_req, 1'b0);
      chk("rst_lo_valid", bus.lo_valid, 1'b0);
      chk("rst_hi_valid", bus.hi_valid, 1'b0);
      chk("rst_blk_idx", {bus.lo_blk_idx, bus.hi_blk_idx}, 4'h0);
      chk("rst_pulses", {bus.lo_block_done, bus.hi_block_done, bus.fmap_done}, 3'b000);
      do_reset();

      for (int c = 0; c < 20; c++) begin
         chk("empty_read_req", bus.read_req, 1'b0);
         chk("empty_valids", {bus.lo_valid, bus.hi_valid}, 2'b00);
         tick();
      end

      for (int v = 0; v < 4; v++) begin
         q.push_back(vt[v].entry);
         wait_rr("vec");
         tick();
         chk("vec_load_valids", {bus.lo_valid, bus.hi_valid}, 2'b00);
         tick();
         chk("vec_valids", {bus.lo_valid, bus.hi_valid}, 2'b11);
         chk("vec_lo_data", bus.lo_data, vt[v].exp_lo);
         chk("vec_hi_data", bus.hi_data, vt[v].exp_hi);
         chk("vec_helps", {bus.lo_help, bus.hi_help}, {vt[v].exp_lo_help, vt[v].exp_hi_help});
         tick();
         chk("vec_valids_drop", {bus.lo_valid, bus.hi_valid}, 2'b00);
      end

      // hi backpressure: lo accepts once, hi holds, second pop waits for hi
      do_reset();
      q.push_back(vt[0].entry);
      q.push_back(vt[1].entry);
      bus.hi_ready = 1'b0;
      wait_rr("bp");
      tick(2);
      chk("bp_valids", {bus.lo_valid, bus.hi_valid}, 2'b11);
      chk("bp_hi_data0", bus.hi_data, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("bp_hi_hold_valid", bus.hi_valid, 1'b1);
         chk("bp_hi_hold_data", bus.hi_data, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
         chk("bp_lo_once", bus.lo_valid, 1'b0);
         chk("bp_no_pop", bus.read_req, 1'b0);
      end
      bus.hi_ready = 1'b1;
      tick();
      chk("bp_pop_after_accept", bus.read_req, 1'b1);
      chk("bp_hi_dropped", bus.hi_valid, 1'b0);
      tick(2);
      chk("bp_second_lo", bus.lo_data, 80'hFEDC_BA98_7654_3210_0FF0);
      chk("bp_second_hi", bus.hi_data, 80'h0123_4567_89AB_CDEF_0011);
      tick();

      // 10 own rows -> one block_done per lane, after the 10th accept
      do_reset();
      push_normal(10, 16);
      monitor(80);
      chk("blk10_lo_pulses", lo_pulses, 1);
      chk("blk10_hi_pulses", hi_pulses, 1);
      chk("blk10_lo_at", lo_at, 10);
      chk("blk10_hi_at", hi_at, 10);
      chk("blk10_idx", {bus.lo_blk_idx, bus.hi_blk_idx}, {2'd1, 2'd1});
      chk("blk10_no_fmap", fm_pulses, 0);

      // helped lo row does not count toward lo's own block
      do_reset();
      q.push_back(vt[1].entry);
      wait_rr("help");
      tick(2);
      chk("help_flags", {bus.lo_help, bus.hi_help}, 2'b10);
      push_normal(9, 64);
      monitor(60);
      chk("help_lo_no_done", lo_pulses, 0);
      chk("help_hi_done", hi_pulses, 1);
      push_normal(1, 90);
      monitor(20);
      chk("help_lo_done_late", lo_pulses, 1);
      chk("help_hi_quiet", hi_pulses, 0);
      chk("help_idx", {bus.lo_blk_idx, bus.hi_blk_idx}, {2'd1, 2'd1});

      // 40 rows -> four blocks per lane, one fmap_done
      do_reset();
      push_normal(40, 200);
      monitor(250);
      chk("fmap_pulses", fm_pulses, 1);
      chk("fmap_lo_blocks", lo_pulses, 4);
      chk("fmap_hi_blocks", hi_pulses, 4);
      chk("fmap_idx", {bus.lo_blk_idx, bus.hi_blk_idx}, 4'h0);

      // async reset while presenting
      do_reset();
      bus.lo_ready = 1'b0;
      bus.hi_ready = 1'b0;
      q.push_back(vt[2].entry);
      wait_rr("rstmid");
      tick(2);
      chk("rstmid_valids_before", {bus.lo_valid, bus.hi_valid}, 2'b11);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_valids_async", {bus.lo_valid, bus.hi_valid}, 2'b00);
      tick();
      bus.lo_ready = 1'b1;
      bus.hi_ready = 1'b1;
      rst_n = 1'b1;
      tick();
      q.push_back(vt[3].entry);
      wait_rr("rstmid_next");
      tick(2);
      chk("rstmid_next_lo", bus.lo_data, 80'h0102_0304_0506_0708_090A);
      chk("rstmid_next_hi", bus.hi_data, 80'h8000_0000_0000_0000_0001);
      tick();
      chk("rstmid_next_drop", {bus.lo_valid, bus.hi_valid}, 2'b00);

      // clk_en low during FETCH: strobe pauses, then exactly one pop
      do_reset();
      q.push_back(vt[0].entry);
      q.push_back(vt[2].entry);
      wait_rr("cen");
      clk_en = 1'b0;
      #1;
      chk("cen_rr_off", bus.read_req, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cen_rr_frozen", bus.read_req, 1'b0);
      end
      clk_en = 1'b1;
      #1;
      chk("cen_rr_resume", bus.read_req, 1'b1);
      tick();
      chk("cen_rr_single", bus.read_req, 1'b0);
      tick();
      chk("cen_first_lo", bus.lo_data, 80'h5555_5555_5555_5555_5555);
      tick();
      wait_rr("cen_second");
      tick(2);
      chk("cen_second_lo", bus.lo_data, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
      chk("cen_second_hi", bus.hi_data, 80'h0);
      tick();
      chk("cen_queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
